// File: rtl/ad_trig_capture_if.sv
// Readout stream from the capture engine toward the packetiser.
// master = capture engine, slave = downstream consumer.
interface ad_trig_capture_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ad_trig_capture.sv
// AD capture engine: decimation, circular pre-trigger history, level/forced trigger,
// and time-ordered replay of one DEPTH-sample record on a valid/ready stream.
module ad_trig_capture #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64,
    parameter int DEC_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_valid,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_fall,
    input  logic              force_trig,
    input  logic [DEC_W-1:0]  decim,
    ad_trig_capture_if.master m,
    output logic              busy,
    output logic              done
);
    localparam int AW     = $clog2(DEPTH);
    localparam int POST_N = DEPTH - PRE_TRIG - 1;

    localparam logic [AW-1:0] PRE_A     = AW'(PRE_TRIG);
    localparam logic [AW-1:0] PRE_LAST  = AW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    localparam logic [AW-1:0] POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);
    localparam logic [AW:0]   LAST_IDX  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   REC_LEN   = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READ} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     cnt;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       rd_cnt;
    logic [DEC_W-1:0]  dec_ratio;
    logic [DEC_W-1:0]  dec_cnt;
    logic [DATA_W-1:0] prev;
    logic              prev_vld;

    // Read pipeline: RAM output stage, one skid entry, then the output register.
    logic [DATA_W-1:0] rd_q;
    logic              rd_vld;
    logic              rd_last;
    logic [DATA_W-1:0] sk_data;
    logic              sk_vld;
    logic              sk_last;

    logic       capturing;
    logic       acc;
    logic       edge_hit;
    logic       trig_hit;
    logic       pop;
    logic [1:0] occ;
    logic       rd_issue;

    always_comb begin
        capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
        acc       = capturing && ad_valid && (dec_cnt == '0);
        edge_hit  = 1'b0;
        if (trig_fall)
            edge_hit = prev_vld && (prev > trig_level) && (ad_data <= trig_level);
        else
            edge_hit = prev_vld && (prev < trig_level) && (ad_data >= trig_level);
        trig_hit = force_trig || edge_hit;
        pop      = m.m_valid && m.m_ready;
        occ      = 2'(m.m_valid) + 2'(sk_vld) + 2'(rd_vld);
        // At most two samples in flight/held, so a stall never overruns the skid entry.
        rd_issue = (state == READ) && (rd_cnt != REC_LEN) && ((occ != 2'd2) || pop);
    end

    always_ff @(posedge clk) begin
        if (acc)
            mem[wp] <= ad_data;
    end

    always_ff @(posedge clk) begin
        if (rd_issue)
            rd_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            m.m_data  <= '0;
            m.m_valid <= 1'b0;
            m.m_last  <= 1'b0;
            wp        <= '0;
            cnt       <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= '0;
            dec_ratio <= '0;
            dec_cnt   <= '0;
            prev      <= '0;
            prev_vld  <= 1'b0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
            sk_data   <= '0;
            sk_vld    <= 1'b0;
            sk_last   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                m.m_valid <= 1'b0;
                m.m_last  <= 1'b0;
                sk_vld    <= 1'b0;
                rd_vld    <= 1'b0;
            end else begin
                rd_vld <= 1'b0;
                if (capturing && ad_valid)
                    dec_cnt <= (dec_cnt == dec_ratio) ? '0 : dec_cnt + DEC_W'(1);
                if (acc) begin
                    prev     <= ad_data;
                    prev_vld <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (arm) begin
                            dec_ratio <= decim;
                            dec_cnt   <= '0;
                            wp        <= '0;
                            cnt       <= '0;
                            prev_vld  <= 1'b0;
                            busy      <= 1'b1;
                            state     <= (PRE_TRIG == 0) ? WAIT_TRIG : PRE;
                        end
                    end
                    PRE: begin
                        if (acc) begin
                            wp  <= wp + AW'(1);
                            cnt <= cnt + AW'(1);
                            if (cnt == PRE_LAST) begin
                                cnt   <= '0;
                                state <= WAIT_TRIG;
                            end
                        end
                    end
                    WAIT_TRIG: begin
                        if (acc) begin
                            wp <= wp + AW'(1);
                            if (trig_hit) begin
                                // Record start is fixed now; the trigger lands at beat PRE_TRIG.
                                rd_ptr <= wp - PRE_A;
                                rd_cnt <= '0;
                                cnt    <= '0;
                                state  <= (POST_N == 0) ? READ : POST;
                            end
                        end
                    end
                    POST: begin
                        if (acc) begin
                            wp  <= wp + AW'(1);
                            cnt <= cnt + AW'(1);
                            if (cnt == POST_LAST)
                                state <= READ;
                        end
                    end
                    READ: begin
                        if (rd_issue) begin
                            rd_ptr  <= rd_ptr + AW'(1);
                            rd_cnt  <= rd_cnt + (AW+1)'(1);
                            rd_vld  <= 1'b1;
                            rd_last <= (rd_cnt == LAST_IDX);
                        end
                        if (!m.m_valid || m.m_ready) begin
                            if (m.m_valid && m.m_last) begin
                                state     <= IDLE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                m.m_valid <= 1'b0;
                                m.m_last  <= 1'b0;
                                sk_vld    <= 1'b0;
                            end else if (sk_vld) begin
                                m.m_data  <= sk_data;
                                m.m_last  <= sk_last;
                                m.m_valid <= 1'b1;
                                sk_vld    <= rd_vld;
                                sk_data   <= rd_q;
                                sk_last   <= rd_last;
                            end else if (rd_vld) begin
                                m.m_data  <= rd_q;
                                m.m_last  <= rd_last;
                                m.m_valid <= 1'b1;
                            end else begin
                                m.m_valid <= 1'b0;
                                m.m_last  <= 1'b0;
                            end
                        end else if (rd_vld) begin
                            sk_vld  <= 1'b1;
                            sk_data <= rd_q;
                            sk_last <= rd_last;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ad_trig_capture.sv
// Bench for ad_trig_capture: table of capture scenarios with an expected-record
// scoreboard, plus abort, reset-during-readout and re-arm sequences.
module tb_ad_trig_capture;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int PRE_TRIG = 4;
    localparam int DEC_W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] ad_data;
    logic              ad_valid;
    logic              arm;
    logic              abort;
    logic [DATA_W-1:0] trig_level;
    logic              trig_fall;
    logic              force_trig;
    logic [DEC_W-1:0]  decim;
    logic              busy;
    logic              done;

    ad_trig_capture_if #(.DATA_W(DATA_W)) bus ();

    ad_trig_capture #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .DEC_W(DEC_W)
    ) dut (
        .clk(clk), .rst(rst), .ad_data(ad_data), .ad_valid(ad_valid), .arm(arm),
        .abort(abort), .trig_level(trig_level), .trig_fall(trig_fall),
        .force_trig(force_trig), .decim(decim), .m(bus), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       start;
        int       step;
        int       dec;
        int       lvl;
        bit       fall;
        int       force_at;
        bit [3:0] rdy;
        int       exp_first;
        int       exp_step;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic run_case(input vec_t v, input int abort_at, input int rst_beats);
        int         beats      = 0;
        int         done_cnt   = 0;
        int         valid_seen = 0;
        bit         held       = 1'b0;
        bit         armed2     = 1'b0;
        bit         rec        = (abort_at < 0);
        logic [7:0] held_data  = '0;
        logic       held_last  = 1'b0;
        logic [7:0] e;
        if (rec)
            for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(v.exp_first + i * v.exp_step));
        @(negedge clk);
        decim      = 8'(v.dec);
        trig_level = 8'(v.lvl);
        trig_fall  = v.fall;
        ad_valid   = 1'b0;
        arm        = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        chk("busy_after_arm", busy, 1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            arm   = 1'b0;
            abort = 1'b0;
            if (done) begin
                done_cnt++;
                chk("valid_after_done", bus.m_valid, 0);
                break;
            end
            if (!rec) begin
                bus.m_ready = 1'b1;
                if (bus.m_valid) valid_seen++;
                if (cyc == abort_at) begin
                    chk("busy_before_abort", busy, 1);
                    abort = 1'b1;
                end
                if (cyc == abort_at + 1) chk("busy_after_abort", busy, 0);
                if (cyc == abort_at + 4) break;
            end else begin
                if (rst_beats >= 0 && beats == rst_beats) begin
                    rst = 1'b1; bus.m_ready = 1'b0; ad_valid = 1'b0;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_m_valid", bus.m_valid, 0);
                    chk("rst_m_last", bus.m_last, 0);
                    chk("rst_m_data", bus.m_data, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    break;
                end
                if (rst_beats >= 0 && beats == 2 && !armed2) begin
                    arm    = 1'b1;
                    armed2 = 1'b1;
                end
                if (held) begin
                    chk("valid_held", bus.m_valid, 1);
                    if (bus.m_valid) begin
                        chk("data_held", bus.m_data, held_data);
                        chk("last_held", bus.m_last, held_last);
                    end
                end
                bus.m_ready = v.rdy[cyc % 4];
                held      = bus.m_valid && !bus.m_ready;
                held_data = bus.m_data;
                held_last = bus.m_last;
                if (bus.m_valid && bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_underflow", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("data_beat%0d", beats), bus.m_data, e);
                    end
                    chk($sformatf("last_beat%0d", beats), bus.m_last, 32'(beats == DEPTH - 1));
                    beats++;
                end
            end
            force_trig = (cyc == v.force_at);
            ad_valid   = 1'b1;
            ad_data    = 8'(v.start + cyc * v.step);
            @(negedge clk);
        end
        force_trig  = 1'b0;
        ad_valid    = 1'b0;
        arm         = 1'b0;
        abort       = 1'b0;
        bus.m_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        if (!rec) begin
            chk("valid_during_abort", valid_seen, 0);
            chk("done_after_abort", done_cnt, 0);
        end else if (rst_beats < 0) begin
            chk("beat_count", beats, DEPTH);
            chk("done_pulses", done_cnt, 1);
            chk("busy_end", busy, 0);
            chk("sb_leftover", exp_q.size(), 0);
        end else begin
            exp_q.delete();
        end
    endtask

    initial begin
        //          start step dec lvl  fall force rdy      first step
        vecs[0] = '{90,   1,  0, 100, 1'b0, -1, 4'b1111,  96,  1};
        vecs[1] = '{90,   1,  1, 100, 1'b0, -1, 4'b1111,  92,  2};
        vecs[2] = '{90,   1,  0, 100, 1'b0, -1, 4'b1001,  96,  1};
        vecs[3] = '{50,   0,  0, 100, 1'b0,  8, 4'b1111,  50,  0};
        vecs[4] = '{120, -1,  0, 100, 1'b1, -1, 4'b1111, 104, -1};
        vecs[5] = '{30,   1,  2,  50, 1'b0, -1, 4'b1111,  39,  3};
        vecs[6] = '{240,  1,  0, 255, 1'b0, -1, 4'b1111, 251,  1};
        vecs[7] = '{150,  1,  0, 100, 1'b0, -1, 4'b1111,  96,  1};

        rst = 1'b1; ad_data = '0; ad_valid = 1'b0; arm = 1'b0; abort = 1'b0;
        trig_level = '0; trig_fall = 1'b0; force_trig = 1'b0; decim = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_m_valid", bus.m_valid, 0);
        chk("reset_m_last", bus.m_last, 0);
        chk("reset_m_data", bus.m_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        for (int i = 0; i < 8; i++) run_case(vecs[i], -1, -1);

        // Abort while still collecting post-trigger samples, then a normal re-arm.
        run_case(vecs[0], 14, -1);
        run_case(vecs[0], -1, -1);

        // Reset after five beats (with a stray arm during readout), then recovery.
        run_case(vecs[0], -1, 5);
        run_case(vecs[1], -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
